imem_boot_loader: RTL and testbench

- Sequences the core's instruction memory at boot. Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Writes the words into the instruction memory's synchronous write port.
- Holds the single-cycle core in reset until the image is fully written. It then releases the core to fetch from address 0.
- Sits between the boot byte source (UART/host bridge) and the instruction memory plus core reset.

---
 rtl/imem_boot_loader_pkg.sv | 17 +
 rtl/imem_boot_loader_if.sv | 22 ++
 rtl/imem_boot_loader_byte_word_packer.sv | 47 ++++
 rtl/imem_boot_loader.sv | 130 +++++++++++++
 tb/tb_imem_boot_loader.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_pkg;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    DONE,
    ERR
  } boot_state_e;

  localparam int INSTR_BYTES = 4;

  // Default memory fill, also the RISC-V canonical NOP (addi x0,x0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Boot byte stream plus instruction-memory write port.
// master = the loader, slave = byte source / memory side.
interface imem_boot_loader_if #(
  parameter int AW = 4
);
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream.
// The word is emitted combinationally together with its last byte.
module byte_word_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0] byte_idx_q;

  // Byte lane pointer: restarts on clear, wraps after the fourth byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx_q <= '0;
    end else if (clear_i) begin
      byte_idx_q <= '0;
    end else if (byte_valid_i) begin
      byte_idx_q <= byte_idx_q + 2'd1;
    end
  end

  // The three lower lanes are stored; the top lane is the byte arriving now.
  for (genvar gi = 0; gi < INSTR_BYTES - 1; gi++) begin : g_lane
    logic [7:0] lane_q;

    // Capture the byte destined for this lane.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        lane_q <= '0;
      end else if (byte_valid_i && (byte_idx_q == 2'(gi))) begin
        lane_q <= byte_i;
      end
    end

    assign word_o[8*gi +: 8] = lane_q;
  end

  assign word_o[31:24] = byte_i;
  assign word_valid_o  = byte_valid_i && (byte_idx_q == 2'(INSTR_BYTES - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte image, writes it into the
// instruction memory and holds the core in reset until the image is complete.
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  imem_boot_loader_if.master   bus,
  input  logic                 load_req,
  output logic                 cpu_run,
  output logic                 busy,
  output logic                 err
);

  boot_state_e state_q, state_d;
  logic [7:0]  len_lo_q, len_lo_d;
  // One bit wider than the address so N == DEPTH is representable.
  logic [AW:0] n_q, n_d;
  logic [AW:0] word_idx_q, word_idx_d;
  logic           mem_we_q, mem_we_d;
  logic [AW-1:0]  mem_waddr_q, mem_waddr_d;
  logic [31:0]    mem_wdata_q, mem_wdata_d;
  logic           cpu_run_q;

  logic        loading;
  logic        accept;
  logic [15:0] hdr_len;
  logic        word_valid;
  logic [31:0] word;

  assign loading = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
  assign accept  = bus.rx_valid && loading;
  assign hdr_len = {bus.rx_data, len_lo_q};

  byte_word_packer u_packer (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_i      (state_q != DATA),
    .byte_valid_i (accept && (state_q == DATA)),
    .byte_i       (bus.rx_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // State, counters and registered memory-port / core-release outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= LEN_LO;
      len_lo_q    <= '0;
      n_q         <= '0;
      word_idx_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      cpu_run_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      n_q         <= n_d;
      word_idx_q  <= word_idx_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      // Delayed one cycle so the final write lands before the first fetch.
      cpu_run_q   <= (state_q == DONE);
    end
  end

  // Next-state logic: header decode, word commit, restart handling.
  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    n_d         = n_q;
    word_idx_d  = word_idx_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      LEN_LO: begin
        if (accept) begin
          len_lo_d = bus.rx_data;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          if ((hdr_len == 16'd0) || (hdr_len > 16'(DEPTH))) begin
            state_d = ERR;
          end else begin
            n_d        = hdr_len[AW:0];
            word_idx_d = '0;
            state_d    = DATA;
          end
        end
      end
      DATA: begin
        if (word_valid) begin
          mem_we_d    = 1'b1;
          mem_waddr_d = word_idx_q[AW-1:0];
          mem_wdata_d = word;
          word_idx_d  = word_idx_q + (AW+1)'(1);
          if (word_idx_q == n_q - (AW+1)'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE, ERR: begin
        if (load_req) begin
          state_d    = LEN_LO;
          len_lo_d   = '0;
          n_d        = '0;
          word_idx_d = '0;
        end
      end
      default: state_d = LEN_LO;
    endcase
  end

  assign bus.rx_ready  = loading;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_run       = cpu_run_q;
  assign busy          = loading;
  assign err           = (state_q == ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: stream-level reference model checked every
// cycle, plus literal expectations on captured writes and memory contents.
module tb_imem_boot_loader;
  import imem_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk;
  logic reset_n;
  logic load_req;
  logic cpu_run;
  logic busy;
  logic err;

  imem_boot_loader_if #(.AW(AW)) bus ();

  imem_boot_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .load_req (load_req),
    .cpu_run  (cpu_run),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory stand-in and write log.
  bit [31:0] imem [DEPTH];
  bit        fill_req;
  int        wr_addr [$];
  bit [31:0] wr_data [$];

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < DEPTH; i++) imem[i] <= NOP_INSTR;
    end else if (reset_n && bus.mem_we) begin
      imem[bus.mem_waddr] <= bus.mem_wdata;
      wr_addr.push_back(int'(bus.mem_waddr));
      wr_data.push_back(bus.mem_wdata);
    end
  end

  // Stream-level model: header bytes, then data bytes counted into words.
  int        m_hdr_cnt;
  int        m_N;
  int        m_bytes;
  bit        m_done;
  bit        m_err;
  bit [7:0]  m_asm [4];
  bit        exp_run;
  bit        exp_we;
  int        exp_waddr;
  bit [31:0] exp_wdata;

  always @(posedge clk or negedge reset_n) begin : model
    int hc, nn, nb, wa;
    bit dn, er, we;
    bit [7:0] a [4];
    bit [31:0] wd;
    if (!reset_n) begin
      m_hdr_cnt <= 0; m_N <= 0; m_bytes <= 0; m_done <= 0; m_err <= 0;
      exp_run <= 0; exp_we <= 0; exp_waddr <= 0; exp_wdata <= 0;
    end else begin
      hc = m_hdr_cnt; nn = m_N; nb = m_bytes; dn = m_done; er = m_err;
      a = m_asm; we = 0; wa = exp_waddr; wd = exp_wdata;
      if (!dn && !er) begin
        if (bus.rx_valid) begin
          if (hc == 0) begin
            nn = int'(bus.rx_data); hc = 1;
          end else if (hc == 1) begin
            nn = nn + 256 * int'(bus.rx_data); hc = 2; nb = 0;
            if (nn == 0 || nn > DEPTH) er = 1;
          end else begin
            a[nb % 4] = bus.rx_data;
            nb++;
            if (nb % 4 == 0) begin
              we = 1; wa = nb / 4 - 1; wd = {a[3], a[2], a[1], a[0]};
              if (nb == 4 * nn) dn = 1;
            end
          end
        end
      end else if (load_req) begin
        hc = 0; nn = 0; nb = 0; dn = 0; er = 0;
      end
      exp_run   <= m_done;
      m_hdr_cnt <= hc; m_N <= nn; m_bytes <= nb; m_done <= dn; m_err <= er;
      m_asm     <= a;
      exp_we    <= we; exp_waddr <= wa; exp_wdata <= wd;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("rx_ready", 32'(bus.rx_ready), 32'(!m_done && !m_err));
    check("busy",     32'(busy),         32'(!m_done && !m_err));
    check("err",      32'(err),          32'(m_err));
    check("cpu_run",  32'(cpu_run),      32'(exp_run));
    check("mem_we",   32'(bus.mem_we),   32'(exp_we));
    if (exp_we) begin
      check("mem_waddr", 32'(bus.mem_waddr), 32'(exp_waddr));
      check("mem_wdata", bus.mem_wdata, exp_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'hA5;
    if (gap) tick();
  endtask

  task automatic send_hdr(input int n, input bit gap);
    logic [15:0] v;
    v = 16'(n);
    send(v[7:0], gap);
    send(v[15:8], gap);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], gap);
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic run_two_word(input string tag, input bit gap);
    clear_log();
    $display("%s: load N=2 gap=%0d", tag, gap);
    send_hdr(2, gap);
    send_word(32'h0001_40B7, gap);
    send_word(32'h0001_4097, gap);
    tick(); tick();
    check({tag, "_nwr"},   32'(wr_addr.size()), 32'd2);
    check({tag, "_a0"},    32'(wr_addr[0]), 32'd0);
    check({tag, "_d0"},    wr_data[0], 32'h0001_40B7);
    check({tag, "_a1"},    32'(wr_addr[1]), 32'd1);
    check({tag, "_d1"},    wr_data[1], 32'h0001_4097);
    check({tag, "_run"},   32'(cpu_run), 32'd1);
    check({tag, "_ready"}, 32'(bus.rx_ready), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    pulse_load();
    check({tag, "_run_hold"}, 32'(cpu_run), 32'd1);
    tick();
    check({tag, "_run_drop"}, 32'(cpu_run), 32'd0);
  endtask

  task automatic run_bad_hdr(input string tag, input int n);
    clear_log();
    $display("%s: header N=%0d", tag, n);
    send_hdr(n, 1'b0);
    bus.rx_valid = 1'b1;  // stream keeps offering data; must stall
    tick(); tick(); tick();
    bus.rx_valid = 1'b0;
    check({tag, "_err"},   32'(err), 32'd1);
    check({tag, "_ready"}, 32'(bus.rx_ready), 32'd0);
    check({tag, "_run"},   32'(cpu_run), 32'd0);
    check({tag, "_nwr"},   32'(wr_addr.size()), 32'd0);
    pulse_load();
    check({tag, "_clr_err"},   32'(err), 32'd0);
    check({tag, "_clr_busy"},  32'(busy), 32'd1);
    check({tag, "_clr_ready"}, 32'(bus.rx_ready), 32'd1);
  endtask

  initial begin : watchdog
    #100000;
    n_mis++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin : stimulus
    reset_n      = 1'b0;
    load_req     = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    fill_req     = 1'b1;
    tick();
    fill_req = 1'b0;
    tick(); tick();
    $display("reset: checking reset values");
    check("rst_ready", 32'(bus.rx_ready), 32'd1);
    check("rst_busy",  32'(busy), 32'd1);
    check("rst_run",   32'(cpu_run), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    check("rst_we",    32'(bus.mem_we), 32'd0);
    check("rst_waddr", 32'(bus.mem_waddr), 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    reset_n = 1'b1;
    tick();

    run_two_word("normal", 1'b0);
    run_two_word("gapped", 1'b1);

    run_bad_hdr("n0", 0);
    run_bad_hdr("n17", 17);

    // Full depth: 16 words, addresses 0..15, no wrap.
    clear_log();
    $display("full: load N=16");
    send_hdr(16, 1'b0);
    for (int i = 0; i < DEPTH; i++) send_word(32'h0000_0013 + 32'(i), 1'b0);
    tick(); tick();
    check("full_nwr",  32'(wr_addr.size()), 32'd16);
    check("full_a15",  32'(wr_addr[15]), 32'd15);
    check("full_d15",  wr_data[15], 32'h0000_0022);
    check("full_run",  32'(cpu_run), 32'd1);
    for (int i = 0; i < DEPTH; i++) check("full_mem", imem[i], 32'h0000_0013 + 32'(i));

    // Reload with a single word; stale words must survive.
    pulse_load();
    tick();
    check("reload_run_drop", 32'(cpu_run), 32'd0);
    clear_log();
    $display("reload: load N=1");
    send_hdr(1, 1'b0);
    send_word(32'h0000_80E7, 1'b0);
    tick(); tick();
    check("reload_nwr", 32'(wr_addr.size()), 32'd1);
    check("reload_a0",  32'(wr_addr[0]), 32'd0);
    check("reload_m0",  imem[0], 32'h0000_80E7);
    check("reload_m1",  imem[1], 32'h0000_0014);
    check("reload_run", 32'(cpu_run), 32'd1);

    // Abort mid-load with reset, then load a fresh image.
    pulse_load();
    tick();
    clear_log();
    $display("abort: reset after 2 data bytes of N=3");
    send_hdr(3, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    reset_n = 1'b0;
    #1;
    check("abort_ready", 32'(bus.rx_ready), 32'd1);
    check("abort_busy",  32'(busy), 32'd1);
    check("abort_run",   32'(cpu_run), 32'd0);
    check("abort_we",    32'(bus.mem_we), 32'd0);
    check("abort_waddr", 32'(bus.mem_waddr), 32'd0);
    check("abort_wdata", bus.mem_wdata, 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("abort_nwr", 32'(wr_addr.size()), 32'd0);
    $display("abort: fresh load N=3");
    send_hdr(3, 1'b0);
    send_word(32'h1122_3344, 1'b0);
    send_word(32'h5566_7788, 1'b0);
    send_word(32'h99AA_BBCC, 1'b0);
    tick(); tick();
    check("fresh_nwr", 32'(wr_addr.size()), 32'd3);
    check("fresh_m0",  imem[0], 32'h1122_3344);
    check("fresh_m1",  imem[1], 32'h5566_7788);
    check("fresh_m2",  imem[2], 32'h99AA_BBCC);
    check("fresh_m3",  imem[3], 32'h0000_0016);
    check("fresh_run", 32'(cpu_run), 32'd1);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
